eth_tx_framer: RTL and testbench

//  Packs a stream of 32-bit acquisition words from stick_main into fixed-length

---
 rtl/eth_tx_framer.sv | 124 ++++++++++++
 tb/tb_eth_tx_framer.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/eth_tx_framer.sv
// Packs 32-bit words into Ethernet frames: 4 header words + PAYLOAD_WORDS payload; first word 1 cycle after i_vld.
// Output register holds while i_tx_rdy=0; optional trailing payload-sum word when TX_SUM_EN is defined.
module eth_tx_framer #(
    parameter logic [47:0] DST_MAC       = 48'hFFFF_FFFF_FFFF,
    parameter logic [47:0] SRC_MAC       = 48'h0002_0304_0506,
    parameter logic [15:0] ETHERTYPE     = 16'h88B5,
    parameter int unsigned PAYLOAD_WORDS = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] i_data,
    input  logic        i_vld,
    output logic        o_rdy,
    output logic [31:0] o_tx_data,
    output logic        o_tx_vld,
    output logic        o_tx_sop,
    output logic        o_tx_eop,
    output logic [1:0]  o_tx_mod,
    input  logic        i_tx_rdy
);
    typedef enum logic [1:0] {IDLE, HDR, PAY, SUM} state_t;

    localparam logic [8:0] LAST_IDX = 9'(PAYLOAD_WORDS - 1);

    state_t      state;
    logic [8:0]  idx;
    logic [15:0] seq;
    logic [31:0] hdr_word;
    logic        load;
`ifdef TX_SUM_EN
    logic [31:0] acc;
`endif

    assign load     = !o_tx_vld || i_tx_rdy;
    assign o_rdy    = (state == PAY) && load;
    assign o_tx_mod = 2'd0;

    // w0 is loaded directly from IDLE; this covers w1..w3 by header index
    always_comb begin
        hdr_word = {ETHERTYPE, seq};
        case (idx[1:0])
            2'd1:    hdr_word = {DST_MAC[15:0], SRC_MAC[47:32]};
            2'd2:    hdr_word = SRC_MAC[31:0];
            default: hdr_word = {ETHERTYPE, seq};
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            idx       <= 9'd0;
            seq       <= 16'd0;
            o_tx_data <= 32'd0;
            o_tx_vld  <= 1'b0;
            o_tx_sop  <= 1'b0;
            o_tx_eop  <= 1'b0;
`ifdef TX_SUM_EN
            acc       <= 32'd0;
`endif
        end else begin
            if (o_tx_vld && i_tx_rdy && o_tx_eop)
                seq <= seq + 16'd1;
            if (load) begin
                o_tx_vld <= 1'b0;
                o_tx_sop <= 1'b0;
                o_tx_eop <= 1'b0;
                case (state)
                    IDLE: begin
                        if (i_vld) begin
                            o_tx_data <= DST_MAC[47:16];
                            o_tx_vld  <= 1'b1;
                            o_tx_sop  <= 1'b1;
                            idx       <= 9'd1;
                            state     <= HDR;
`ifdef TX_SUM_EN
                            acc       <= 32'd0;
`endif
                        end
                    end
                    HDR: begin
                        o_tx_data <= hdr_word;
                        o_tx_vld  <= 1'b1;
                        if (idx == 9'd3) begin
                            idx   <= 9'd0;
                            state <= PAY;
                        end else begin
                            idx <= idx + 9'd1;
                        end
                    end
                    PAY: begin
                        // a missing upstream word leaves a bubble; idx counts accepted words only
                        if (i_vld) begin
                            o_tx_data <= i_data;
                            o_tx_vld  <= 1'b1;
`ifdef TX_SUM_EN
                            acc       <= acc + i_data;
`endif
                            if (idx == LAST_IDX) begin
                                idx   <= 9'd0;
`ifdef TX_SUM_EN
                                state <= SUM;
`else
                                o_tx_eop <= 1'b1;
                                state    <= IDLE;
`endif
                            end else begin
                                idx <= idx + 9'd1;
                            end
                        end
                    end
`ifdef TX_SUM_EN
                    SUM: begin
                        o_tx_data <= acc;
                        o_tx_vld  <= 1'b1;
                        o_tx_eop  <= 1'b1;
                        state     <= IDLE;
                    end
`endif
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_eth_tx_framer.sv
// Directed bench for eth_tx_framer with PAYLOAD_WORDS=11; frames captured at each transfer and compared to a header/payload model.
module tb_eth_tx_framer;
    localparam int PW = 11;
`ifdef TX_SUM_EN
    localparam int FW = PW + 5;
`else
    localparam int FW = PW + 4;
`endif
    localparam logic [31:0] W0 = 32'hFFFF_FFFF;
    localparam logic [31:0] W1 = 32'hFFFF_0002;
    localparam logic [31:0] W2 = 32'h0304_0506;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] i_data = 32'd0;
    logic        i_vld = 1'b0;
    logic        o_rdy;
    logic [31:0] o_tx_data;
    logic        o_tx_vld, o_tx_sop, o_tx_eop;
    logic [1:0]  o_tx_mod;
    logic        i_tx_rdy = 1'b1;

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    int bubbles = 0;
    int sop_cyc = 0;
    int eop_cyc = 0;
    int sop_gap = 0;
    int vld_cyc = 0;
    bit in_frame = 0;
    bit mod_bad = 0;
    logic [33:0] txq[$];
    logic [31:0] exp_pay[$];
    logic [33:0] last_word;

    eth_tx_framer #(.PAYLOAD_WORDS(PW)) dut (
        .clk(clk), .reset(reset), .i_data(i_data), .i_vld(i_vld), .o_rdy(o_rdy),
        .o_tx_data(o_tx_data), .o_tx_vld(o_tx_vld), .o_tx_sop(o_tx_sop),
        .o_tx_eop(o_tx_eop), .o_tx_mod(o_tx_mod), .i_tx_rdy(i_tx_rdy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // transfers are decided at the next posedge; inputs and outputs are stable here
    always @(negedge clk) begin
        if (reset) begin
            in_frame = 0;
        end else begin
            if (o_tx_mod != 2'd0) mod_bad = 1;
            if (in_frame && !o_tx_vld) bubbles++;
            if (o_tx_vld && i_tx_rdy) begin
                txq.push_back({o_tx_sop, o_tx_eop, o_tx_data});
                if (o_tx_sop) begin
                    sop_cyc  = cyc;
                    sop_gap  = cyc - eop_cyc;
                    in_frame = 1;
                end
                if (o_tx_eop) begin
                    eop_cyc  = cyc;
                    in_frame = 0;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic fill_pay(input int n, input logic [31:0] base);
        exp_pay.delete();
        for (int i = 0; i < n; i++) exp_pay.push_back(base + 32'(i));
    endtask

    task automatic run_payload(input int off, input int n, input int gap_at, input int gap_len);
        int sent = 0;
        int gap = 0;
        int t = 0;
        bit first = 1;
        while (sent < n && t < 2000) begin
            @(posedge clk); #1;
            if (sent == gap_at && gap < gap_len) begin
                i_vld = 1'b0;
                gap++;
            end else begin
                i_vld  = 1'b1;
                i_data = exp_pay[off + sent];
                if (first) begin
                    vld_cyc = cyc;
                    first = 0;
                end
            end
            @(negedge clk);
            t++;
            if (i_vld && o_rdy) sent++;
        end
        @(posedge clk); #1;
        i_vld = 1'b0;
        chk("payload_accepted", 64'(sent), 64'(n));
    endtask

    task automatic check_frame(input string tag, input logic [15:0] sq, input int off);
        int t = 0;
        logic [31:0] sum = 32'd0;
        logic [31:0] ew;
        logic [33:0] got;
        while (txq.size() < FW && t < 400) begin
            @(negedge clk);
            t++;
        end
        if (txq.size() < FW) begin
            chk($sformatf("%s_timeout", tag), 64'(txq.size()), 64'(FW));
            return;
        end
        for (int i = 0; i < FW; i++) begin
            case (i)
                0: ew = W0;
                1: ew = W1;
                2: ew = W2;
                3: ew = {16'h88B5, sq};
                default: begin
                    if (i < PW + 4) begin
                        ew = exp_pay[off + i - 4];
                        sum = sum + ew;
                    end else begin
                        ew = sum;
                    end
                end
            endcase
            got = txq.pop_front();
            chk($sformatf("%s_w%0d", tag, i), 64'(got), 64'({(i == 0), (i == FW - 1), ew}));
            last_word = got;
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_vld", 64'(o_tx_vld), 64'd0);
        chk("rst_data", 64'(o_tx_data), 64'd0);
        chk("rst_sop_eop", 64'({o_tx_sop, o_tx_eop}), 64'd0);
        chk("rst_rdy", 64'(o_rdy), 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // single frame, payload 1..11
        fill_pay(PW, 32'd1);
        begin
            int b0 = bubbles;
            run_payload(0, PW, -1, 0);
            check_frame("f1", 16'd0, 0);
            chk("sop_latency", 64'(sop_cyc - vld_cyc), 64'd1);
            chk("f1_bubbles", 64'(bubbles - b0), 64'd0);
        end

        // three back-to-back frames, then seq wrap
        fill_pay(3 * PW, 32'd100);
        run_payload(0, 3 * PW, -1, 0);
        check_frame("b2b_a", 16'd1, 0);
        check_frame("b2b_b", 16'd2, PW);
        check_frame("b2b_c", 16'd3, 2 * PW);
        chk("b2b_sop_gap", 64'(sop_gap), 64'd1);
        @(posedge clk); #1;
        force dut.seq = 16'hFFFF;
        @(negedge clk);
        release dut.seq;
        run_payload(0, 2 * PW, -1, 0);
        check_frame("wrap_a", 16'hFFFF, 0);
        check_frame("wrap_b", 16'h0000, PW);

        // backpressure: stall 5 cycles while third payload word is on the output
        fill_pay(PW, 32'd200);
        fork
            run_payload(0, PW, -1, 0);
            begin
                repeat (8) @(posedge clk);
                #1 i_tx_rdy = 1'b0;
                for (int i = 0; i < 5; i++) begin
                    @(negedge clk);
                    chk($sformatf("bp_hold%0d", i), 64'({o_tx_vld, o_tx_sop, o_tx_eop, o_tx_data}),
                        64'({3'b100, 32'd202}));
                    chk($sformatf("bp_rdy%0d", i), 64'(o_rdy), 64'd0);
                end
                @(posedge clk); #1 i_tx_rdy = 1'b1;
            end
        join
        check_frame("bp", 16'd1, 0);

        // upstream underflow of 3 cycles after 5 payload words
        fill_pay(PW, 32'd300);
        begin
            int b0 = bubbles;
            run_payload(0, PW, 5, 3);
            check_frame("uf", 16'd2, 0);
            chk("uf_bubbles", 64'(bubbles - b0), 64'd3);
        end

        // reset while w2 is on the output
        @(posedge clk); #1;
        i_vld  = 1'b1;
        i_data = 32'hDEAD_BEEF;
        repeat (3) @(posedge clk);
        #1 chk("rst_mid_w2", 64'({o_tx_vld, o_tx_data}), 64'({1'b1, W2}));
        reset = 1'b1;
        #1;
        chk("rst_mid_out", 64'({o_tx_vld, o_tx_sop, o_tx_eop, o_tx_data}), 64'd0);
        chk("rst_mid_rdy", 64'(o_rdy), 64'd0);
        i_vld = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        txq.delete();
        fill_pay(PW, 32'd400);
        run_payload(0, PW, -1, 0);
        check_frame("after_rst", 16'd0, 0);

`ifdef TX_SUM_EN
        exp_pay.delete();
        exp_pay.push_back(32'hFFFF_FFFF);
        exp_pay.push_back(32'hFFFF_FFFF);
        for (int i = 0; i < PW - 2; i++) exp_pay.push_back(32'd0);
        run_payload(0, PW, -1, 0);
        check_frame("sum", 16'd1, 0);
        chk("sum_word", 64'(last_word), 64'({2'b01, 32'hFFFF_FFFE}));
`endif

        chk("tx_mod_zero", 64'(mod_bad), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
